// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Holds the register-address and data widths, the write-request struct used
// for every candidate register-file write, and a one-hot address decoder
// used to build the pending-register mask.
package writeback_arbiter_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // One-hot decode of a register address.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_AW-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = {NUM_REGS{1'b0}};
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bus bundle between the pipeline / long-latency unit and the arbiter.
//   p_*       : pipeline WB-stage write request (never back-pressured)
//   l_*       : long-latency unit result with ready/valid handshake
//   RegWrite_o, RDaddr_o, RDdata_o : register-file write port
//   pend_mask_o, stall_o, collision_o : hazard, stall and error status
// master = producer/consumer side (pipeline, L unit, register file),
// slave  = the arbiter.
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  logic                p_valid_i;
  logic [REG_AW-1:0]   p_addr_i;
  logic [DATA_W-1:0]   p_data_i;
  logic                l_valid_i;
  logic                l_ready_o;
  logic [REG_AW-1:0]   l_addr_i;
  logic [DATA_W-1:0]   l_data_i;
  logic                RegWrite_o;
  logic [REG_AW-1:0]   RDaddr_o;
  logic [DATA_W-1:0]   RDdata_o;
  logic [NUM_REGS-1:0] pend_mask_o;
  logic                stall_o;
  logic                collision_o;

  modport master (
    output p_valid_i, p_addr_i, p_data_i, l_valid_i, l_addr_i, l_data_i,
    input  l_ready_o, RegWrite_o, RDaddr_o, RDdata_o, pend_mask_o, stall_o, collision_o
  );

  modport slave (
    input  p_valid_i, p_addr_i, p_data_i, l_valid_i, l_addr_i, l_data_i,
    output l_ready_o, RegWrite_o, RDaddr_o, RDdata_o, pend_mask_o, stall_o, collision_o
  );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: DEPTH-entry in-order buffer for long-latency results.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push          : write request; push.valid is the push strobe
//   pop           : remove the head entry
//   full, empty   : occupancy status of the current contents
//   head          : current head entry (head.valid == !empty)
//   ent_valid_nxt, ent_addr_nxt : per-slot valid/address as they will be
//                   after this edge, so the owner can register a mask that
//                   tracks the contents without an extra cycle of lag.
// Each slot carries its own valid bit, so no separate occupancy counter is
// kept: the slot under the write pointer is valid only when full, and the
// slot under the read pointer is invalid only when empty.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  wb_req_t                      push,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output wb_req_t                      head,
  output logic [DEPTH-1:0]             ent_valid_nxt,
  output logic [DEPTH-1:0][REG_AW-1:0] ent_addr_nxt
);

  localparam int unsigned PW = $clog2(DEPTH);

  wb_req_t [DEPTH-1:0] mem_r;
  wb_req_t [DEPTH-1:0] mem_nxt_s;
  logic    [PW-1:0]    rd_ptr_r;
  logic    [PW-1:0]    wr_ptr_r;
  logic                pop_ok_s;
  logic                push_ok_s;

  assign head  = mem_r[rd_ptr_r];
  assign empty = !mem_r[rd_ptr_r].valid;
  assign full  = mem_r[wr_ptr_r].valid;

  // Next slot contents; push and pop can never target the same slot because
  // rd == wr only when the buffer is empty (no pop) or full (no push).
  always_comb begin
    pop_ok_s      = pop && !empty;
    push_ok_s     = push.valid && !full;
    mem_nxt_s     = mem_r;
    ent_valid_nxt = {DEPTH{1'b0}};
    ent_addr_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok_s && (wr_ptr_r == PW'(i))) begin
        mem_nxt_s[i] = push;
      end else if (pop_ok_s && (rd_ptr_r == PW'(i))) begin
        mem_nxt_s[i].valid = 1'b0;
      end else begin
        mem_nxt_s[i] = mem_r[i];
      end
      ent_valid_nxt[i] = mem_nxt_s[i].valid;
      ent_addr_nxt[i]  = mem_nxt_s[i].addr;
    end
  end

  // Slot storage and pointers; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_r    <= '0;
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
    end else begin
      mem_r <= mem_nxt_s;
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the pipeline WB-stage write and buffered
// long-latency results onto a single register-file write port.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : writeback_arbiter_if.slave (request inputs, RF write
//                  port, pending mask, stall request, collision flag)
// The pipeline always wins; buffered results drain in order when the
// pipeline is idle. A starve counter raises an advisory stall once the
// buffer has been passed over STARVE_LIMIT times, and a sticky collision
// flag records a pipeline write to a register that still has a buffered
// result pending (both writes still happen, pipeline first).
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  writeback_arbiter_if.slave  bus
);

  localparam int unsigned   SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  wb_req_t                      head_s;
  wb_req_t                      push_s;
  wb_req_t                      win_s;
  logic                         pop_s;
  logic                         fifo_full_s;
  logic                         fifo_empty_s;
  logic [DEPTH-1:0]             ent_valid_nxt_s;
  logic [DEPTH-1:0][REG_AW-1:0] ent_addr_nxt_s;
  logic [SW-1:0]                starve_r;
  logic [SW-1:0]                starve_nxt_s;
  logic [NUM_REGS-1:0]          mask_nxt_s;
  logic [NUM_REGS-1:0]          pend_mask_r;
  logic                         collision_hit_s;
  logic                         l_ready_r;
  logic                         regwrite_r;
  logic [REG_AW-1:0]            rdaddr_r;
  logic [DATA_W-1:0]            rddata_r;
  logic                         stall_r;
  logic                         collision_r;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push          (push_s),
    .pop           (pop_s),
    .full          (fifo_full_s),
    .empty         (fifo_empty_s),
    .head          (head_s),
    .ent_valid_nxt (ent_valid_nxt_s),
    .ent_addr_nxt  (ent_addr_nxt_s)
  );

  // L handshake and buffer pop; the full check is redundant with l_ready_r
  // but keeps a push into a full buffer impossible by construction.
  always_comb begin
    push_s       = '0;
    push_s.valid = bus.l_valid_i && l_ready_r && !fifo_full_s;
    push_s.addr  = bus.l_addr_i;
    push_s.data  = bus.l_data_i;
    pop_s        = !bus.p_valid_i && !fifo_empty_s;
  end

  // Fixed-priority winner selection: pipeline, then buffer head, else none.
  always_comb begin
    win_s = '0;
    if (bus.p_valid_i) begin
      win_s.valid = 1'b1;
      win_s.addr  = bus.p_addr_i;
      win_s.data  = bus.p_data_i;
    end else if (!fifo_empty_s) begin
      win_s = head_s;
    end else begin
      win_s = '0;
    end
  end

  // Starve counter next value: clear on pop, count lost cycles, saturate.
  always_comb begin
    starve_nxt_s = starve_r;
    if (pop_s) begin
      starve_nxt_s = {SW{1'b0}};
    end else if (!fifo_empty_s && bus.p_valid_i && (starve_r != LIMIT_C)) begin
      starve_nxt_s = starve_r + SW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Pending mask of the post-edge buffer contents; address 0 is included.
  always_comb begin
    mask_nxt_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid_nxt_s[i]) begin
        mask_nxt_s = mask_nxt_s | addr_onehot(ent_addr_nxt_s[i]);
      end else begin
        mask_nxt_s = mask_nxt_s;
      end
    end
  end

  // A pipeline write to a register with a buffered result still pending.
  always_comb begin
    collision_hit_s = bus.p_valid_i && (bus.p_addr_i != {REG_AW{1'b0}})
                      && pend_mask_r[bus.p_addr_i];
  end

  // Status registers: starve counter, stall, mask, ready, sticky collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_r    <= {SW{1'b0}};
      stall_r     <= 1'b0;
      pend_mask_r <= {NUM_REGS{1'b0}};
      l_ready_r   <= 1'b1;
      collision_r <= 1'b0;
    end else begin
      starve_r    <= starve_nxt_s;
      stall_r     <= (starve_nxt_s == LIMIT_C);
      pend_mask_r <= mask_nxt_s;
      l_ready_r   <= !(&ent_valid_nxt_s);
      collision_r <= collision_r | collision_hit_s;
    end
  end

  // Register-file write port; address/data hold when there is no winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regwrite_r <= 1'b0;
      rdaddr_r   <= {REG_AW{1'b0}};
      rddata_r   <= {DATA_W{1'b0}};
    end else begin
      regwrite_r <= win_s.valid && (win_s.addr != {REG_AW{1'b0}});
      if (win_s.valid) begin
        rdaddr_r <= win_s.addr;
        rddata_r <= win_s.data;
      end
    end
  end

  assign bus.l_ready_o   = l_ready_r;
  assign bus.RegWrite_o  = regwrite_r;
  assign bus.RDaddr_o    = rdaddr_r;
  assign bus.RDdata_o    = rddata_r;
  assign bus.pend_mask_o = pend_mask_r;
  assign bus.stall_o     = stall_r;
  assign bus.collision_o = collision_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  writeback_arbiter_if bus();

  writeback_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  // Behavioural model state
  ent_t        q[$];
  int          starve   = 0;
  bit          live     = 1'b0;
  logic        exp_rw   = 1'b0;
  logic [4:0]  exp_addr = 5'd0;
  logic [31:0] exp_data = 32'd0;
  logic        exp_stall = 1'b0;
  logic        exp_coll  = 1'b0;

  function automatic logic [31:0] q_mask();
    logic [31:0] m;
    m = 32'd0;
    foreach (q[i]) m = m | (32'd1 << q[i].addr);
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one call per rising edge, from the arbitration rules directly.
  initial begin : model_proc
    logic [31:0] m;
    bit          push;
    ent_t        e;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        starve    = 0;
        exp_rw    = 1'b0;
        exp_addr  = 5'd0;
        exp_data  = 32'd0;
        exp_stall = 1'b0;
        exp_coll  = 1'b0;
        live      = 1'b1;
      end else if (live) begin
        m = q_mask();
        if (bus.p_valid_i && bus.p_addr_i != 5'd0 && m[bus.p_addr_i]) exp_coll = 1'b1;
        push = bus.l_valid_i && (q.size() < DEPTH);
        if (bus.p_valid_i) begin
          exp_rw   = (bus.p_addr_i != 5'd0);
          exp_addr = bus.p_addr_i;
          exp_data = bus.p_data_i;
          if (q.size() > 0 && starve < LIMIT) starve++;
        end else if (q.size() > 0) begin
          e        = q.pop_front();
          exp_rw   = (e.addr != 5'd0);
          exp_addr = e.addr;
          exp_data = e.data;
          starve   = 0;
        end else begin
          exp_rw = 1'b0;
        end
        if (push) begin
          e.addr = bus.l_addr_i;
          e.data = bus.l_data_i;
          q.push_back(e);
        end
        exp_stall = (starve == LIMIT);
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (live) begin
        chk("RegWrite",  {31'd0, bus.RegWrite_o},  {31'd0, exp_rw});
        chk("RDaddr",    {27'd0, bus.RDaddr_o},    {27'd0, exp_addr});
        chk("RDdata",    bus.RDdata_o,             exp_data);
        chk("pend_mask", bus.pend_mask_o,          q_mask());
        chk("stall",     {31'd0, bus.stall_o},     {31'd0, exp_stall});
        chk("collision", {31'd0, bus.collision_o}, {31'd0, exp_coll});
        chk("l_ready",   {31'd0, bus.l_ready_o},   (q.size() < DEPTH) ? 32'd1 : 32'd0);
      end
    end
  end

  task automatic drive(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bus.p_valid_i = pv;
    bus.p_addr_i  = pa;
    bus.p_data_i  = pd;
    bus.l_valid_i = lv;
    bus.l_addr_i  = la;
    bus.l_data_i  = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin : stim_proc
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // Reset values
    chk("rst_RegWrite",  {31'd0, bus.RegWrite_o}, 32'd0);
    chk("rst_RDaddr",    {27'd0, bus.RDaddr_o},   32'd0);
    chk("rst_RDdata",    bus.RDdata_o,            32'd0);
    chk("rst_mask",      bus.pend_mask_o,         32'd0);
    chk("rst_stall",     {31'd0, bus.stall_o},    32'd0);
    chk("rst_coll",      {31'd0, bus.collision_o},32'd0);
    chk("rst_l_ready",   {31'd0, bus.l_ready_o},  32'd1);

    // P writes r5 = 0xAA
    drive(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
    tick();
    chk("p_RegWrite", {31'd0, bus.RegWrite_o}, 32'd1);
    chk("p_RDaddr",   {27'd0, bus.RDaddr_o},   32'd5);
    chk("p_RDdata",   bus.RDdata_o,            32'h0000_00AA);
    chk("model_rw",   {31'd0, exp_rw},         32'd1);
    idle();
    tick();
    chk("idle_RegWrite", {31'd0, bus.RegWrite_o}, 32'd0);
    chk("idle_hold_addr", {27'd0, bus.RDaddr_o},  32'd5);
    chk("idle_hold_data", bus.RDdata_o,           32'h0000_00AA);

    // L pushes r7 = 0x1234 with P idle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_1234);
    tick();
    chk("l_mask7",    bus.pend_mask_o,         32'h0000_0080);
    chk("l_noWrite",  {31'd0, bus.RegWrite_o}, 32'd0);
    idle();
    tick();
    chk("l_RegWrite", {31'd0, bus.RegWrite_o}, 32'd1);
    chk("l_RDaddr",   {27'd0, bus.RDaddr_o},   32'd7);
    chk("l_RDdata",   bus.RDdata_o,            32'h0000_1234);
    chk("l_mask0",    bus.pend_mask_o,         32'd0);

    // Starvation: P busy 6 cycles, L pushes r3 then r4
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 5'(10 + c), 32'(c), (c < 2), (c == 0) ? 5'd3 : 5'd4,
            (c == 0) ? 32'h33 : 32'h44);
      tick();
      if (c == 0) chk("st_ready_c0", {31'd0, bus.l_ready_o}, 32'd1);
      if (c == 1) chk("st_ready_c1", {31'd0, bus.l_ready_o}, 32'd0);
      if (c == 3) chk("st_stall_c3", {31'd0, bus.stall_o},   32'd0);
      if (c == 4) chk("st_stall_c4", {31'd0, bus.stall_o},   32'd1);
      if (c == 4) chk("model_stall", {31'd0, exp_stall},     32'd1);
      if (c == 5) chk("st_RDaddr_c5", {27'd0, bus.RDaddr_o}, 32'd15);
    end
    idle();
    tick();
    chk("st_w3_addr", {27'd0, bus.RDaddr_o},   32'd3);
    chk("st_w3_data", bus.RDdata_o,            32'h33);
    chk("st_w3_we",   {31'd0, bus.RegWrite_o}, 32'd1);
    chk("st_stall_off", {31'd0, bus.stall_o},  32'd0);
    tick();
    chk("st_w4_addr", {27'd0, bus.RDaddr_o},   32'd4);
    chk("st_w4_we",   {31'd0, bus.RegWrite_o}, 32'd1);
    chk("st_mask0",   bus.pend_mask_o,         32'd0);
    tick();
    chk("st_quiet",   {31'd0, bus.RegWrite_o}, 32'd0);

    // Address 0 from both sources
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    tick();
    chk("r0_we_a",  {31'd0, bus.RegWrite_o}, 32'd0);
    chk("r0_mask",  bus.pend_mask_o,         32'd1);
    idle();
    tick();
    chk("r0_we_b",  {31'd0, bus.RegWrite_o}, 32'd0);
    chk("r0_drain", bus.pend_mask_o,         32'd0);

    // Collision on r9
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    tick();
    chk("co_mask9", bus.pend_mask_o,          32'h0000_0200);
    chk("co_pre",   {31'd0, bus.collision_o}, 32'd0);
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
    tick();
    chk("co_set",   {31'd0, bus.collision_o}, 32'd1);
    chk("co_p_data", bus.RDdata_o,            32'h55);
    idle();
    tick();
    chk("co_l_addr", {27'd0, bus.RDaddr_o},   32'd9);
    chk("co_l_data", bus.RDdata_o,            32'h99);
    tick();
    chk("co_sticky", {31'd0, bus.collision_o}, 32'd1);

    // Reset with two entries buffered, inputs active during reset
    drive(1'b1, 5'd20, 32'd1, 1'b1, 5'd1, 32'h11);
    tick();
    drive(1'b1, 5'd21, 32'd2, 1'b1, 5'd2, 32'h22);
    tick();
    chk("rb_mask",   bus.pend_mask_o,        32'h0000_0006);
    chk("rb_qsize",  32'(q.size()),          32'd2);
    rst = 1'b1;
    drive(1'b1, 5'd22, 32'd3, 1'b1, 5'd3, 32'h33);
    tick();
    rst = 1'b0;
    idle();
    chk("rb_we",     {31'd0, bus.RegWrite_o}, 32'd0);
    chk("rb_mask0",  bus.pend_mask_o,         32'd0);
    chk("rb_ready",  {31'd0, bus.l_ready_o},  32'd1);
    chk("rb_coll",   {31'd0, bus.collision_o},32'd0);
    tick();
    chk("rb_nowr1",  {31'd0, bus.RegWrite_o}, 32'd0);
    tick();
    chk("rb_nowr2",  {31'd0, bus.RegWrite_o}, 32'd0);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 15)), $urandom);
      tick();
    end
    rst = 1'b0;
    idle();
    for (int n = 0; n < 6; n++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk_i, reset port rst_i.
REQ-002 Parameter DEPTH, 2, long-latency buffer entries; power of two, 2 to 8.
REQ-003 Parameter STARVE_LIMIT, 4, consecutive lost cycles before a stall is requested.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 p_valid_i  in  1  pipeline (WB stage) write request; cannot be back-pressured.
REQ-007 p_addr_i  in  5  pipeline destination register.
REQ-008 p_data_i  in  32  pipeline write data.
REQ-009 l_valid_i  in  1  long-latency unit (mul/div) result valid.
REQ-010 l_ready_o  out  1  buffer can accept an L result this cycle.
REQ-011 l_addr_i  in  5  L destination register.
REQ-012 l_data_i  in  32  L result data.
REQ-013 RegWrite_o  out  1  register-file write enable.
REQ-014 RDaddr_o  out  5  register-file write address.
REQ-015 RDdata_o  out  32  register-file write data.
REQ-016 pend_mask_o  out  32  bit n set while a buffered L entry targets register n; feeds hazard detection.
REQ-017 stall_o  out  1  request that the pipeline hold issue.
REQ-018 collision_o  out  1  sticky error flag.

Function
REQ-019 The L transfer SHALL occur when l_valid_i and l_ready_o are both 1; l_ready_o = buffer not full, registered.
REQ-020 Each accepted L result SHALL enter a DEPTH-entry FIFO; FIFO order SHALL equal acceptance order.
REQ-021 Each cycle the winner SHALL be: P if p_valid_i; else the FIFO head if the FIFO is non-empty; else none.
REQ-022 The winner SHALL appear on RegWrite_o/RDaddr_o/RDdata_o exactly one cycle later (registered outputs).
REQ-023 A winner with address 0 SHALL be consumed but SHALL drive RegWrite_o = 0.
REQ-024 With no winner, RegWrite_o SHALL be 0; RDaddr_o and RDdata_o SHALL hold their previous values.
REQ-025 A FIFO pop and an L push in the same cycle SHALL leave the count unchanged; a push while full SHALL be impossible (l_ready_o = 0).
REQ-026 pend_mask_o SHALL be the registered OR of the one-hot decode of every valid FIFO entry's address, including address 0.
REQ-027 The starve counter SHALL increment each cycle the FIFO is non-empty and P wins; it SHALL clear on any FIFO pop; it SHALL saturate at STARVE_LIMIT.
REQ-028 stall_o SHALL be 1 in every cycle after the counter equals STARVE_LIMIT, until the cycle after the next FIFO pop.
REQ-029 stall_o SHALL be advisory: P SHALL still win if p_valid_i = 1 while stall_o = 1.
REQ-030 collision_o SHALL set when p_valid_i = 1 and p_addr_i != 0 and pend_mask_o[p_addr_i] = 1; it SHALL clear only on reset.
REQ-031 On a collision, the P write SHALL proceed; the FIFO entry SHALL be written later, unmodified.

Reset
REQ-032 When rst_i = 1 at a rising edge: FIFO empty; read and write pointers 0; starve counter 0.
REQ-033 Reset values of outputs: RegWrite_o 0, RDaddr_o 0, RDdata_o 0, pend_mask_o 0, stall_o 0, collision_o 0, l_ready_o 1 from the first cycle after reset.
REQ-034 Reset mid-operation SHALL discard all buffered entries without writing them.
REQ-035 Reset SHALL take priority over all simultaneous requests.

Structure
REQ-036 A shared package SHALL hold the register-address width (5), the data width (32) and a write-request struct {valid, addr, data}.
REQ-037 The FIFO SHALL be one sub-module, wb_fifo (DEPTH, push/pop/full/empty, per-entry address and valid visible for the mask).
REQ-038 Arbitration, the starve counter, the collision flag and the output registers SHALL reside in writeback_arbiter.

Verification
REQ-039 Idle L, P writes r5 = 0x0000_00AA -> next cycle RegWrite_o = 1, RDaddr_o = 5, RDdata_o = 0xAA.
REQ-040 P idle, L pushes r7 = 0x1234 -> pend_mask_o bit 7 set for 1 cycle, then RegWrite_o = 1, RDaddr_o = 7, RDdata_o = 0x1234; mask returns to 0.
REQ-041 Two L pushes (r3, r4) with P valid for 6 straight cycles -> l_ready_o = 0 after the second push; stall_o = 1 from cycle 5; after P stops, r3 then r4 are written on consecutive cycles; stall_o drops.
REQ-042 P writes r0 and L pushes r0 -> RegWrite_o never asserts; FIFO drains; pend_mask_o bit 0 is set for 1 cycle.
REQ-043 L pushes r9, then P writes r9 while it is pending -> collision_o = 1 and stays 1; P write to r9 first, then L write to r9.
REQ-044 Reset asserted with 2 entries buffered -> no writes follow; pend_mask_o = 0, l_ready_o = 1 after reset.
